// File: rtl/divisor.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// Uses restoring shift-subtract on operand magnitudes, one quotient bit per cycle, and writes the result back to the register file.
module divisor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        wr_ena,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data
);

  // state | meaning
  // IDLE  | waiting for start; last result held on wr_data/wr_reg
  // CALC  | 32 restoring iterations, one quotient bit per cycle
  // FIN   | sign-correct the result and register it for write-back
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic        rem_op;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  cnt;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, ovf;
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] result;

  always_comb begin
    a_neg    = ~op[0] & reg1[31];
    b_neg    = ~op[0] & reg2[31];
    a_mag    = a_neg ? -reg1 : reg1;
    b_mag    = b_neg ? -reg2 : reg2;
    div_zero = (reg2 == 32'd0);
    ovf      = ~op[0] && (reg1 == 32'h8000_0000) && (reg2 == 32'hFFFF_FFFF);
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, dvs};
    fits     = ~diff[32];
    result   = rem_op ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem_op  <= 1'b0;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      quo     <= 32'd0;
      rem     <= 32'd0;
      dvs     <= 32'd0;
      cnt     <= 5'd0;
      done    <= 1'b0;
      wr_ena  <= 1'b0;
      wr_reg  <= 5'd0;
      wr_data <= 32'd0;
    end else begin
      done   <= 1'b0;
      wr_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem_op <= op[1];
            rd_q   <= rd_in;
            if (div_zero || ovf) begin
              // special cases bypass the iteration with final values preloaded
              quo   <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
              rem   <= div_zero ? reg1 : 32'd0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIN;
            end else begin
              quo   <= a_mag;
              rem   <= 32'd0;
              dvs   <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= 5'd31;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= fits ? diff[31:0] : shifted[31:0];
          quo <= {quo[30:0], fits};
          if (cnt == 5'd0) state <= FIN;
          else             cnt   <= cnt - 5'd1;
        end
        FIN: begin
          done    <= 1'b1;
          wr_ena  <= (rd_q != 5'd0);
          wr_reg  <= rd_q;
          wr_data <= result;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, register address width fixed at 5 bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 reg1  input  32  dividend (register-file read port 1).
REQ-007 reg2  input  32  divisor (register-file read port 2).
REQ-008 rd_in  input  5  destination register address for the result.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 wr_ena  output  1  register-file write enable; one-cycle pulse.
REQ-012 wr_reg  output  5  register-file write address.
REQ-013 wr_data  output  32  result: quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-014 FSM states: IDLE, CALC, FIN. IDLE->CALC on start with a normal case; IDLE->FIN on start with a special case; CALC->FIN after the 32nd iteration; FIN->IDLE unconditionally.
REQ-015 On accepting start, latch op, rd_in, reg1 and reg2; later input changes do not affect the operation in flight.
REQ-016 start while busy=1 is ignored: no queuing, no effect on the current operation.
REQ-017 Normal case: restoring shift-subtract on operand magnitudes, one quotient bit per cycle, exactly 32 CALC cycles.
REQ-018 Signed ops (DIV/REM): magnitude = two's-complement absolute value. Quotient negated iff operand signs differ. Remainder takes the dividend's sign.
REQ-019 Unsigned ops (DIVU/REMU): operands are used as-is.
REQ-020 Special case, divisor = 0: quotient 0xFFFFFFFF; remainder = dividend. Applies to all four ops.
REQ-021 Special case, DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000; remainder 0.
REQ-022 Latency: start accepted at edge N.
- Normal case: done=1 in the cycle following edge N+33.
- Special case: done=1 in the cycle following edge N+1.
REQ-023 In FIN: done=1; wr_reg=latched rd_in; wr_data=result; wr_ena=1 only if latched rd_in != 0.
REQ-024 wr_data and wr_reg hold their last values after FIN until the next FIN. done and wr_ena are 0 outside FIN.
REQ-025 Back-to-back operation: start may be accepted in the IDLE cycle immediately after FIN, giving a minimum issue interval of 34 cycles (normal case).
REQ-026 Dividend smaller in magnitude than divisor: quotient 0, remainder = dividend. Follows the normal path with full latency.

Reset
REQ-027 rst_n=0 forces, immediately and asynchronously: state=IDLE, busy=0, done=0, wr_ena=0, wr_reg=0, wr_data=0, and all internal iteration registers to 0.
REQ-028 Reset asserted mid-operation aborts it: no done pulse and no write for that operation, even after release.
REQ-029 After rst_n rises, the first edge may accept start.

Verification
REQ-030 DIV reg1=20, reg2=0xFFFFFFFD (-3), rd_in=5 -> after 33 cycles: done=1, wr_ena=1, wr_reg=5, wr_data=0xFFFFFFFA (-6), all for exactly one cycle.
REQ-031 REM 20 by -3 -> wr_data=2. REM 0xFFFFFFEC (-20) by 3 -> wr_data=0xFFFFFFFE (-2).
REQ-032 REMU reg1=7, reg2=0 -> done one cycle after start, wr_data=7. DIVU 7 by 0 -> wr_data=0xFFFFFFFF.
REQ-033 DIV 0x80000000 by 0xFFFFFFFF -> wr_data=0x80000000 after one cycle. REM with the same operands -> wr_data=0.
REQ-034 DIVU 0xFFFFFFFF by 1, rd_in=0 -> after 33 cycles: done=1, wr_ena=0, wr_data=0xFFFFFFFF.
REQ-035 Second start pulse 10 cycles into an operation, plus rst_n low for one cycle during a second operation:
- First operation: completes with its own result; the extra start is ignored.
- Second operation: outputs go to 0 immediately on reset, busy=0, and no wr_ena ever appears for it.
